// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request, ALU and response signals of the ALU sequencer
interface alu_sequencer_if #(parameter int WIDTH = 16, parameter int OPW = 8);
  logic req_valid, req_ready;
  logic [OPW-1:0] req_opcode;
  logic [WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0] alu_a, alu_b, alu_c;
  logic [OPW-1:0] alu_opcode;
  logic alu_carry, alu_flag, alu_low;
  logic rsp_valid, rsp_ready, rsp_error;
  logic [WIDTH-1:0] rsp_c;
  logic flag_carry, flag_overflow, flag_low, flag_negative, flag_zero;
  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_c, alu_carry, alu_flag, alu_low, rsp_ready,
    input req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_c, rsp_error,
    input flag_carry, flag_overflow, flag_low, flag_negative, flag_zero
  );
  modport slave (
    input req_valid, req_opcode, req_a, req_b, alu_c, alu_carry, alu_flag, alu_low, rsp_ready,
    output req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_c, rsp_error,
    output flag_carry, flag_overflow, flag_low, flag_negative, flag_zero
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready sequencer for the 16-bit ALU; define ALU_SEQ_FLAGS_EN to include the PSR flag register
module alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int OPW = 8,
  parameter int NOP_OP = 24,
  parameter int MAX_OP = 23
) (
  input logic clk,
  input logic reset,
  alu_sequencer_if.slave s
);
  localparam logic [OPW-1:0] NOP = OPW'(NOP_OP);
  localparam logic [OPW-1:0] MAX = OPW'(MAX_OP);
  localparam logic [OPW-1:0] ADD_HI = OPW'(9);
  localparam logic [OPW-1:0] CMP_HI = OPW'(13);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && s.req_valid) state_n = s.req_opcode <= MAX ? EXEC : RESP;
    if (state == EXEC) state_n = RESP;
    if (state == RESP && s.rsp_ready) state_n = IDLE;
  end
  assign s.req_ready = state == IDLE;
  assign s.rsp_valid = state == RESP;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s.alu_a <= '0;
      s.alu_b <= '0;
      s.alu_opcode <= NOP;
      s.rsp_c <= '0;
      s.rsp_error <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && s.req_valid) begin
        s.alu_a <= s.req_a;
        s.alu_b <= s.req_b;
        s.alu_opcode <= s.req_opcode > NOP ? NOP : s.req_opcode;
        s.rsp_c <= '0;
        s.rsp_error <= s.req_opcode > NOP;
      end
      if (state == EXEC) s.rsp_c <= s.alu_c;
      if (state == RESP && s.rsp_ready) s.alu_opcode <= NOP;
    end
  end
`ifdef ALU_SEQ_FLAGS_EN
  logic carry, ovf, low, neg, zero;
  // only legal opcodes reach EXEC, so anything above CMP_HI is logic/shift
  always_ff @(posedge clk) begin
    if (reset) begin
      {carry, ovf, low, neg, zero} <= '0;
    end else if (state == EXEC) begin
      if (s.alu_opcode <= ADD_HI) {carry, ovf} <= {s.alu_carry, s.alu_flag};
      if (s.alu_opcode > ADD_HI && s.alu_opcode <= CMP_HI) low <= s.alu_low;
      if (s.alu_opcode <= ADD_HI || s.alu_opcode > CMP_HI) {neg, zero} <= {s.alu_c[WIDTH-1], s.alu_c == '0};
    end
  end
  assign {s.flag_carry, s.flag_overflow, s.flag_low, s.flag_negative, s.flag_zero} = {carry, ovf, low, neg, zero};
`else
  logic unused_alu_status;
  assign unused_alu_status = ^{s.alu_carry, s.alu_flag, s.alu_low};
  assign {s.flag_carry, s.flag_overflow, s.flag_low, s.flag_negative, s.flag_zero} = '0;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;
  logic clk = 0;
  logic reset = 1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  alu_sequencer_if #(.WIDTH(16), .OPW(8)) bus ();
  alu_sequencer dut (.clk(clk), .reset(reset), .s(bus.slave));
  typedef struct {
    logic [15:0] c;
    logic err;
    logic [4:0] f;
  } exp_t;
  exp_t q[$];
  logic m_c = 0, m_v = 0, m_l = 0, m_n = 0, m_z = 0;
  function automatic logic [18:0] alu_f(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    logic [15:0] c;
    logic cy, v, lo;
    t = '0;
    cy = 0;
    v = 0;
    lo = 0;
    if (op <= 4) begin
      t = {1'b0, a} + {1'b0, b};
      c = t[15:0];
      cy = t[16];
      v = (a[15] == b[15]) && (c[15] != a[15]);
    end else if (op <= 9) begin
      t = {1'b0, a} - {1'b0, b};
      c = t[15:0];
      cy = t[16];
      v = (a[15] != b[15]) && (c[15] != a[15]);
    end else if (op <= 13) begin
      c = a - b;
      lo = $signed(a) < $signed(b);
    end else if (op == 14) c = a & b;
    else if (op == 15) c = a | b;
    else if (op == 16) c = a ^ b;
    else c = a << 1;
    return {cy, v, lo, c};
  endfunction
  assign {bus.alu_carry, bus.alu_flag, bus.alu_low, bus.alu_c} = alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] flags();
    return {bus.flag_carry, bus.flag_overflow, bus.flag_low, bus.flag_negative, bus.flag_zero};
  endfunction
  always @(negedge clk) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (q.size() == 0) check("unexpected_rsp", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_c", bus.rsp_c, e.c);
        check("rsp_error", bus.rsp_error, e.err);
        check("flags", flags(), e.f);
      end
    end
  end
  task automatic do_op(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [18:0] r;
    logic legal;
    exp_t e;
    int n;
    r = alu_f(op, a, b);
    legal = op <= 23;
`ifdef ALU_SEQ_FLAGS_EN
    if (legal) begin
      if (op <= 9) {m_c, m_v, m_n, m_z} = {r[18], r[17], r[15], r[15:0] == 16'h0};
      else if (op <= 13) m_l = r[16];
      else {m_n, m_z} = {r[15], r[15:0] == 16'h0};
    end
`endif
    e.c = legal ? r[15:0] : 16'h0;
    e.err = op > 24;
    e.f = {m_c, m_v, m_l, m_n, m_z};
    q.push_back(e);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1;
    bus.req_opcode = op;
    bus.req_a = a;
    bus.req_b = b;
    @(posedge clk); #1;
    bus.req_opcode = 8'h40;
    bus.req_a = ~a;
    n = 0;
    while (!bus.rsp_valid && n < 8) begin
      check("req_ready_exec", bus.req_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, legal ? 1 : 0);
    check("alu_opcode", bus.alu_opcode, legal ? op : 8'd24);
    check("alu_a", bus.alu_a, a);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_ready", bus.req_ready, 0);
      check("hold_c", bus.rsp_c, e.c);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
    bus.req_valid = 0;
    check("retire_valid", bus.rsp_valid, 0);
    check("retire_ready", bus.req_ready, 1);
    check("retire_opcode", bus.alu_opcode, 24);
    check("ignored_req", bus.alu_a, a);
  endtask
  initial begin
    bus.req_valid = 0;
    bus.req_opcode = 0;
    bus.req_a = 0;
    bus.req_b = 0;
    bus.rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("rst_ready", bus.req_ready, 1);
    check("rst_valid", bus.rsp_valid, 0);
    check("rst_c", bus.rsp_c, 0);
    check("rst_err", bus.rsp_error, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_opcode", bus.alu_opcode, 24);
    check("rst_flags", flags(), 0);
    do_op(8'd0, 16'h7FFF, 16'h0001, 0);
    do_op(8'd1, 16'hFFFF, 16'h0001, 1);
    do_op(8'd10, 16'hFFFF, 16'h0001, 0);
    do_op(8'h40, 16'h1234, 16'h5678, 2);
    do_op(8'd24, 16'hAAAA, 16'h5555, 0);
    do_op(8'd14, 16'h00F0, 16'h0F00, 5);
    do_op(8'd5, 16'h0001, 16'h0002, 0);
    do_op(8'd23, 16'h8001, 16'h0000, 1);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] op;
      op = 8'($urandom_range(0, 25));
      if (op == 25) op = 8'hC3;
      do_op(op, 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
    end
    do_op(8'd0, 16'h8000, 16'h8000, 0);
    bus.req_valid = 1;
    bus.req_opcode = 8'd1;
    bus.req_a = 16'h1111;
    bus.req_b = 16'h2222;
    @(posedge clk); #1;
    bus.req_valid = 0;
    reset = 1;
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    reset = 0;
    {m_c, m_v, m_l, m_n, m_z} = '0;
    check("midrst_ready", bus.req_ready, 1);
    check("midrst_valid", bus.rsp_valid, 0);
    check("midrst_flags", flags(), 0);
    check("midrst_opcode", bus.alu_opcode, 24);
    check("midrst_c", bus.rsp_c, 0);
    repeat (4) begin
      @(posedge clk); #1;
      check("midrst_quiet", bus.rsp_valid, 0);
    end
    bus.rsp_ready = 0;
    do_op(8'd16, 16'hFF00, 16'h0FF0, 1);
    check("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
